// File: rtl/mc_main_fsm.sv
// mc_main_fsm
// Main control state machine for the multicycle RV32I core. It steps the
// shared datapath through fetch, decode and execute over several cycles per
// instruction. It also counts retired instructions and enters a sticky trap
// state when it decodes an illegal opcode.
//
// Memory handshake: the FSM holds mem_req high, with stable AdrSrc, MemWrite
// and datapath controls, until mem_ready is seen. The transfer completes in
// the cycle where mem_req and mem_ready are both high. The FSM ignores
// mem_ready in any state that does not request memory.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   op             IR opcode field
//   Zero           ALU zero flag (branch condition)
//   mem_ready      memory completes the current request this cycle
//   mem_req        memory request valid
//   AdrSrc         memory address: 0 = PC, 1 = Result
//   MemWrite       write strobe, qualified by mem_req
//   IRWrite        load IR and OldPC
//   PCWrite        load PC (PCUpdate | Branch & Zero)
//   RegWrite       register-file write enable
//   ResultSrc      00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA        00 = PC, 01 = OldPC, 10 = RD1
//   ALUSrcB        00 = RD2, 01 = ImmExt, 10 = constant 4
//   ALUOp          00 = add, 01 = sub, 10 = funct decode
//   retire         one-cycle pulse when an instruction completes
//   instret        retired-instruction count (wraps)
//   trap           illegal opcode seen; sticky until reset
//   o_dbg_state    current state register, for observation
module mc_main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [3:0]       o_dbg_state
);

  typedef enum logic [3:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t           r_state;
  state_t           w_next;
  logic             w_pc_update;
  logic             w_branch;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    mem_req     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    retire      = 1'b0;
    trap        = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        // PC + 4 comes straight from the ALU into PC while the IR loads.
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite     = 1'b1;
          w_pc_update = 1'b1;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm is captured in ALUOut as the branch/jump target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_JAL: begin
        // The target sits in ALUOut from DECODE; the ALU forms OldPC + 4 as
        // the link value, which ALUWB writes back.
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_BOOT;
      end
    endcase
    // Zero reaches PCWrite in the same cycle; no register in the path.
    PCWrite = w_pc_update | (w_branch & Zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (retire) begin
      r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret     = r_instret;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mc_main_fsm.md
# mc_main_fsm

Main control state machine for the multicycle RV32I core. Sequences the shared datapath (single ALU, unified instruction/data memory, IR, OldPC, ALUOut and Data registers) over several cycles per instruction. It replaces the combinational main decoder of the single-cycle core and emits ALUOp to the existing alu_decoder. Memory accesses use a ready handshake, and illegal opcodes drive the core into a sticky trap.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field of the IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- AdrSrc  out  1  memory address source: 0 = PC, 1 = Result.
- MemWrite  out  1  write strobe, qualified by mem_req.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC.
- RegWrite  out  1  register-file write enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A source: 00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  ALU B source: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode by funct3/funct7.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  illegal opcode seen; sticky until reset.

## Operation

- States: BOOT, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, TRAP.
- Outputs are decoded from the state register. Any signal not listed for a state is 0.
- BOOT: all outputs 0. Next state is FETCH.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate follow mem_ready. On mem_ready go to DECODE; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. On mem_ready go to MEMWB; otherwise stay.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Next state is FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1, ResultSrc=00. On mem_ready: retire=1 and go to FETCH; otherwise stay.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state is ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Next state is FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Next state is FETCH.
- TRAP: all datapath outputs 0, trap=1. The FSM stays in TRAP until rst_n is asserted.
- PCWrite = PCUpdate | (Branch & Zero). This is combinational, so Zero affects PCWrite in the same cycle.
- instret increments by 1 on every retire pulse and wraps modulo 2^CNT_W.

## Timing

- Reset (rst_n=0, asynchronous): state=BOOT, instret=0. Every output is 0 immediately, including mem_req and MemWrite, with no clock edge needed. This holds even when reset arrives mid-access.
- The first fetch request is issued 1 cycle after rst_n deasserts: BOOT lasts one cycle.
- Latency with mem_ready=1, counted in cycles from FETCH entry:
  - lw: 5
  - sw: 4
  - R-type / I-type: 4
  - jal: 4
  - beq: 3
- Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. During the stall, addresses and control signals hold stable and IRWrite, PCUpdate and retire stay 0.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- retire is never high for two consecutive cycles.
- instret is updated on the clock edge that ends the retire cycle.

## Test plan

- lw, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5. retire is pulsed once and instret goes 0→1.
- beq with Zero=1 in the BEQ cycle: PCWrite=1 and ALUOp=01 in that cycle. Repeat with Zero=0: PCWrite stays 0. Both cases retire.
- Fetch stall, mem_ready=0 for 3 cycles then 1: FETCH is held for 4 cycles. IRWrite and PCWrite are 1 only in the 4th cycle; mem_req stays 1 throughout.
- op=0000000 at DECODE: the FSM enters TRAP and trap=1. No RegWrite, MemWrite or PCWrite occurs over the next 20 cycles; rst_n clears trap.
- sw with mem_ready=0, then rst_n pulsed low mid-MEMWRITE: MemWrite and mem_req drop in the same cycle without a clock edge, and instret=0. After release, one BOOT cycle precedes FETCH.
- CNT_W=4, 17 back-to-back addi: instret reads 0 after 16 retires and 1 after the 17th.
